// File: rtl/rng_arbiter.sv
// Round-robin arbiter handing out words from a shared external 16-bit LFSR,
// owning the LFSR seeding (boot seed, zero-lockup recovery, entropy reseed).
module rng_arbiter #(
  parameter int          N_REQ        = 4,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             seed_req,
  input  logic [15:0]      lfsr_out,
  output logic             lfsr_w_en,
  output logic [15:0]      lfsr_w_in,
  output logic [N_REQ-1:0] ack,
  output logic [15:0]      rnd_data,
  output logic             ready
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    BOOT, INIT, RUN, GRANT, RESEED
  } state_t;

  state_t             state, state_nx;
  logic [PW-1:0]      rr_ptr, off, win, ptr_nx;
  logic [PW:0]        sum;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot, onehot;
  logic [15:0]        ent_cnt, seed_val;
  logic               pending, any_req;

  // Rotate requests so rr_ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    dbl     = {req, req} >> rr_ptr;
    rot     = dbl[N_REQ-1:0];
    off     = '0;
    any_req = |rot;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = PW'(k);
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
    win    = sum[PW-1:0];
    ptr_nx = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
    onehot = N_REQ'(1) << win;
  end

  always_comb begin
    state_nx  = state;
    lfsr_w_en = 1'b0;
    lfsr_w_in = '0;
    ready     = 1'b0;
    unique case (state)
      BOOT:   state_nx = INIT;
      INIT: begin
        state_nx  = RUN;
        lfsr_w_en = 1'b1;
        lfsr_w_in = SEED_DEFAULT;
      end
      RESEED: begin
        state_nx  = RUN;
        lfsr_w_en = 1'b1;
        lfsr_w_in = seed_val;
      end
      GRANT: begin
        state_nx = RUN;
        ready    = 1'b1;
      end
      RUN: begin
        ready = 1'b1;
        if (lfsr_out == '0)            state_nx = INIT;
        else if (pending || seed_req)  state_nx = RESEED;
        else if (any_req)              state_nx = GRANT;
      end
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      rr_ptr   <= '0;
      ent_cnt  <= '0;
      seed_val <= '0;
      pending  <= 1'b0;
      ack      <= '0;
      rnd_data <= '0;
    end else begin
      state   <= state_nx;
      ent_cnt <= ent_cnt + 16'd1;
      // A zero-lockup reload wins over a reseed, so the seed stays pending.
      if (state == RUN && state_nx == RESEED) begin
        pending  <= 1'b0;
        seed_val <= ent_cnt | 16'h0001;
      end else if (seed_req) begin
        pending <= 1'b1;
      end
      if (state == RUN && state_nx == GRANT) begin
        ack      <= onehot;
        rnd_data <= lfsr_out;
        rr_ptr   <= ptr_nx;
      end else begin
        ack      <= '0;
        rnd_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rng_arbiter.sv
// Bench for rng_arbiter: transaction-level reference model compared every
// cycle, random traffic, plus literal checks on the key scenarios.
module tb_rng_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic        seed_req;
  logic [15:0] lfsr_out;
  logic        lfsr_w_en;
  logic [15:0] lfsr_w_in;
  logic [3:0]  ack;
  logic [15:0] rnd_data;
  logic        ready;

  rng_arbiter #(.N_REQ(4), .SEED_DEFAULT(16'hACE1)) dut (
    .clk(clk), .rst(rst), .req(req), .seed_req(seed_req),
    .lfsr_out(lfsr_out), .lfsr_w_en(lfsr_w_en), .lfsr_w_in(lfsr_w_in),
    .ack(ack), .rnd_data(rnd_data), .ready(ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: what the block is doing this cycle, in plain terms.
  localparam int M_OFF   = 0;
  localparam int M_LOAD  = 1;
  localparam int M_SERVE = 2;
  localparam int M_ACK   = 3;

  int          mode;
  int          ptr;
  bit          pend;
  logic [15:0] ent_m;
  logic [15:0] load_val;
  logic [3:0]  e_ack;
  logic [15:0] e_data;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode  = M_OFF;
    ptr   = 0;
    pend  = 0;
    ent_m = 16'd0;
    e_ack = 4'd0;
    e_data = 16'd0;
  endtask

  // Advance the model across one rising edge given this cycle's inputs.
  task automatic model_edge(input logic [3:0] r, input logic s,
                            input logic [15:0] lo);
    int nm;
    nm = M_SERVE;
    e_ack  = 4'd0;
    e_data = 16'd0;
    if (mode == M_OFF) begin
      nm = M_LOAD;
      load_val = 16'hACE1;
      if (s) pend = 1;
    end else if (mode != M_SERVE) begin
      if (s) pend = 1;
    end else if (lo == 16'd0) begin
      nm = M_LOAD;
      load_val = 16'hACE1;
      if (s) pend = 1;
    end else if (pend || s) begin
      nm = M_LOAD;
      load_val = ent_m | 16'h0001;
      pend = 0;
    end else if (r != 4'd0) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (ptr + k) % 4;
        if (r[i] && nm != M_ACK) begin
          nm     = M_ACK;
          e_ack  = 4'b0001 << i;
          e_data = lo;
          ptr    = (i + 1) % 4;
        end
      end
    end
    mode  = nm;
    ent_m = ent_m + 16'd1;
  endtask

  task automatic compare_all();
    logic        x_wen, x_rdy;
    logic [15:0] x_win;
    x_wen = (mode == M_LOAD);
    x_win = (mode == M_LOAD) ? load_val : 16'd0;
    x_rdy = (mode == M_SERVE) || (mode == M_ACK);
    chk("lfsr_w_en", 16'(lfsr_w_en), 16'(x_wen));
    chk("lfsr_w_in", lfsr_w_in, x_win);
    chk("ack", 16'(ack), 16'(e_ack));
    chk("rnd_data", rnd_data, e_data);
    chk("ready", 16'(ready), 16'(x_rdy));
  endtask

  // Called at a falling edge: drive, step model, compare at next falling edge.
  task automatic step(input logic [3:0] r, input logic s,
                      input logic [15:0] lo);
    req      = r;
    seed_req = s;
    lfsr_out = lo;
    model_edge(r, s, lo);
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"}, 16'(ack), 16'd0);
    chk({tag, "_ready"}, 16'(ready), 16'd0);
    chk({tag, "_wen"}, 16'(lfsr_w_en), 16'd0);
    chk({tag, "_win"}, lfsr_w_in, 16'd0);
    chk({tag, "_data"}, rnd_data, 16'd0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_zero("boot");
  endtask

  logic [3:0]  want;
  logic [3:0]  hold;
  logic [15:0] lo_r;
  int          wait_cnt [4];
  int          max_wait;
  int          gorder [$];
  int          gstep  [$];

  initial begin
    rst = 1'b1; req = 4'd0; seed_req = 1'b0; lfsr_out = 16'h1111;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    release_rst();

    // Boot sequence and a single grant
    step(4'd0, 1'b0, 16'h1111);
    chk("boot_wen", 16'(lfsr_w_en), 16'd1);
    chk("boot_seed", lfsr_w_in, 16'hACE1);
    step(4'd0, 1'b0, 16'h1111);
    chk("boot_ready", 16'(ready), 16'd1);
    step(4'b0100, 1'b0, 16'h5A3C);
    chk("single_ack", 16'(ack), 16'h0004);
    chk("single_data", rnd_data, 16'h5A3C);
    step(4'd0, 1'b0, 16'h5A3C);
    chk("single_ack_off", 16'(ack), 16'd0);

    // Random traffic
    want = 4'd0;
    max_wait = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      want = want & ~e_ack;
      for (int i = 0; i < 4; i++) begin
        if (want[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        if ($urandom_range(0, 3) == 0) want[i] = 1'b1;
      end
      lo_r = 16'($urandom);
      if (lo_r == 16'd0) lo_r = 16'h0001;
      if ($urandom_range(0, 29) == 0) lo_r = 16'd0;
      step(want, ($urandom_range(0, 39) == 0), lo_r);
    end
    chk("wait_bounded", 16'(max_wait <= 40), 16'd1);

    // Entropy reseed at a known counter value
    while (ent_m != 16'h1234) step(4'd0, 1'b0, 16'h0F0F);
    chk("pre_seed_ready", 16'(ready), 16'd1);
    step(4'd0, 1'b1, 16'h0F0F);
    chk("reseed_wen", 16'(lfsr_w_en), 16'd1);
    chk("reseed_val", lfsr_w_in, 16'h1235);
    chk("reseed_noack", 16'(ack), 16'd0);
    step(4'd0, 1'b0, 16'h0F0F);
    step(4'b0001, 1'b0, 16'h2222);
    chk("g_ack", 16'(ack), 16'h0001);
    step(4'd0, 1'b1, 16'h3333);
    chk("g_seed_run", 16'(lfsr_w_en), 16'd0);
    chk("g_seed_rdy", 16'(ready), 16'd1);
    step(4'd0, 1'b0, 16'h3333);
    chk("g_seed_reseed", 16'(lfsr_w_en), 16'd1);
    step(4'd0, 1'b0, 16'h3333);

    // Zero lockup with a request waiting
    step(4'b0010, 1'b0, 16'h0000);
    chk("zero_wen", 16'(lfsr_w_en), 16'd1);
    chk("zero_seed", lfsr_w_in, 16'hACE1);
    chk("zero_noack", 16'(ack), 16'd0);
    step(4'b0010, 1'b0, 16'h4444);
    chk("zero_run_noack", 16'(ack), 16'd0);
    step(4'b0010, 1'b0, 16'h4444);
    chk("zero_served", 16'(ack), 16'h0002);

    // Reset during a grant
    step(4'd0, 1'b0, 16'h5555);
    step(4'b0100, 1'b0, 16'h5555);
    chk("pre_rst_ack", 16'(ack), 16'h0004);
    rst = 1'b1;
    #1;
    check_zero("mid_grant_rst");
    @(negedge clk);
    release_rst();
    step(4'd0, 1'b0, 16'h6666);
    step(4'd0, 1'b0, 16'h6666);

    // All four requesting: rotation from pointer 0, one grant per 2 cycles
    hold = 4'd0;
    for (int n = 0; n < 10; n++) begin
      step(4'hF & ~hold, 1'b0, 16'(16'h7000 + n));
      if (ack != 4'd0) begin
        hold = ack;
        for (int i = 0; i < 4; i++) if (ack[i]) gorder.push_back(i);
        gstep.push_back(n);
      end
    end
    chk("rot_count", 16'(gorder.size()), 16'd5);
    if (gorder.size() == 5 && gstep.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("rot_order", 16'(gorder[k]), 16'(k % 4));
        chk("rot_spacing", 16'(gstep[k]), 16'(2 * k));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/rng_arbiter.md
RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters.
REQ-002 The block SHALL have parameter SEED_DEFAULT, default 16'hACE1, nonzero power-up seed.
REQ-003 The block SHALL have port clk  input  1  clock, all state changes on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port req  input  N_REQ  level request per requester for one random word.
REQ-006 The block SHALL have port seed_req  input  1  single-cycle pulse requesting reseed from entropy counter.
REQ-007 The block SHALL have port lfsr_out  input  16  current value of the shared 16-bit LFSR.
REQ-008 The block SHALL have port lfsr_w_en  output  1  LFSR load enable.
REQ-009 The block SHALL have port lfsr_w_in  output  16  LFSR load value.
REQ-010 The block SHALL have port ack  output  N_REQ  one-hot, one-cycle grant pulse.
REQ-011 The block SHALL have port rnd_data  output  16  random word, valid while any ack bit is high.
REQ-012 The block SHALL have port ready  output  1  high when the LFSR is seeded and serving.

Function
REQ-013 The FSM SHALL have states BOOT, INIT, RUN, GRANT, RESEED.
REQ-014 BOOT SHALL go to INIT unconditionally; all outputs are 0 in BOOT.
REQ-015 INIT SHALL drive lfsr_w_en=1, lfsr_w_in=SEED_DEFAULT for one cycle, then go to RUN.
REQ-016 RESEED SHALL drive lfsr_w_en=1, lfsr_w_in=ent_cnt|16'h0001 (value latched on entry) for one cycle, then go to RUN.
REQ-017 lfsr_w_en SHALL be 0 and lfsr_w_in SHALL be 0 in BOOT, RUN and GRANT.
REQ-018 ent_cnt SHALL be a 16-bit free-running counter, +1 every clock, wraps 16'hFFFF->0.
REQ-019 ready SHALL be 1 in RUN and GRANT only.
REQ-020 RUN priority: lfsr_out==0 -> INIT; else seed pending -> RESEED; else any req bit -> GRANT; else stay RUN.
REQ-021 The arbiter SHALL select the first asserted req bit at or after rr_ptr, searching upward with wrap from N_REQ-1 to 0.
REQ-022 On the RUN->GRANT edge the block SHALL register ack=one-hot of winner i and rnd_data=lfsr_out sampled that cycle; rr_ptr <= (i+1) mod N_REQ.
REQ-023 GRANT SHALL last exactly one cycle with ack and rnd_data held, then return to RUN; req is not arbitrated during GRANT.
REQ-024 Latency: req high in RUN cycle t -> ack in cycle t+1; at most one grant per 2 cycles.
REQ-025 A requester SHALL drop req in the cycle after its ack; a req still high in the following RUN cycle counts as a new request.
REQ-026 ack SHALL be all-zero and rnd_data SHALL be 0 outside GRANT.
REQ-027 seed_req arriving in any state other than RUN SHALL set a pending flag; the flag is cleared on entry to RESEED.
REQ-028 seed_req and lfsr_out==0 in the same RUN cycle SHALL go to INIT and keep the pending flag set.
REQ-029 Requests blocked by INIT/RESEED SHALL be served once back in RUN; none are dropped.

Reset
REQ-030 rst high SHALL immediately force state=BOOT, rr_ptr=0, ent_cnt=0, pending=0, ack=0, rnd_data=0, lfsr_w_en=0, lfsr_w_in=0, ready=0.
REQ-031 Reset asserted during GRANT/INIT/RESEED SHALL abort the operation with no further ack or load pulse.

Verification
REQ-032 Release rst -> cycle 1 BOOT (all outputs 0), cycle 2 lfsr_w_en=1 with lfsr_w_in=16'hACE1, cycle 3 ready=1.
REQ-033 In RUN, req=4'b0100, lfsr_out=16'h5A3C -> next cycle ack=4'b0100, rnd_data=16'h5A3C, then ack=0.
REQ-034 req=4'b1111 held, each requester drops after ack and reasserts -> grant order 0,1,2,3,0, one ack every 2 cycles.
REQ-035 seed_req pulse in RUN with ent_cnt=16'h1234 -> next cycle lfsr_w_en=1, lfsr_w_in=16'h1235, no ack; seed_req in GRANT -> RESEED follows the next RUN cycle.
REQ-036 lfsr_out forced to 16'h0000 in RUN with req pending -> INIT reload of 16'hACE1 before any ack.
REQ-037 rst asserted mid-GRANT -> ack=0 and ready=0 immediately; rr_ptr=0 after release.
